// File: rtl/dct8_stream.sv
`default_nettype none
// =============================================================================
// Module   : dct8_stream
// Brief    : Streaming 8-point DCT-II / DCT-III engine, ping-pong input
//            buffers, serial MAC and a 2-entry output FIFO.
// Revision : 1.0
// =============================================================================
module dct8_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 12,
    parameter int OUT_WIDTH  = DATA_WIDTH + 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_inv,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2:0]                   out_index,
    output logic                         out_last,
    output logic                         out_inv,
    output logic                         busy
);
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + 3;
    localparam logic signed [ACC_W-1:0] C_RND     = ACC_W'(longint'(1) << (COEF_WIDTH - 2));
    localparam logic signed [ACC_W-1:0] C_OUT_MAX = ACC_W'((longint'(1) << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] C_OUT_MIN = ACC_W'(-(longint'(1) << (OUT_WIDTH - 1)));

    // cos(m*pi/16) in Q30, m = 0..8
    function automatic longint cos_q30(input int m);
        case (m)
            0:       cos_q30 = 64'sd1073741824;
            1:       cos_q30 = 64'sd1053110176;
            2:       cos_q30 = 64'sd992008094;
            3:       cos_q30 = 64'sd892783698;
            4:       cos_q30 = 64'sd759250125;
            5:       cos_q30 = 64'sd596538995;
            6:       cos_q30 = 64'sd410903207;
            7:       cos_q30 = 64'sd209476638;
            default: cos_q30 = 64'sd0;
        endcase
    endfunction

    // a(0)*cos(0) equals (1/2)*cos(pi/4), so every entry is half a folded cosine.
    function automatic logic signed [COEF_WIDTH-1:0] coef(input int k, input int n);
        int     m;
        bit     neg;
        longint mag;
        m   = ((2 * n + 1) * k) % 32;
        if (m > 16) m = 32 - m;
        neg = 1'b0;
        if (m > 8) begin
            m   = 16 - m;
            neg = 1'b1;
        end
        mag = (k == 0) ? cos_q30(4) : cos_q30(m);
        mag = (mag * (longint'(1) << (COEF_WIDTH - 2)) + (longint'(1) << 29)) >>> 30;
        coef = neg ? COEF_WIDTH'(-mag) : COEF_WIDTH'(mag);
    endfunction

    logic signed [COEF_WIDTH-1:0] w_rom [64];
    for (genvar gk = 0; gk < 8; gk++) begin : g_rom_k
        for (genvar gn = 0; gn < 8; gn++) begin : g_rom_n
            localparam logic signed [COEF_WIDTH-1:0] C_VAL = coef(gk, gn);
            assign w_rom[gk*8+gn] = C_VAL;
        end
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  buf_q [2][8];
    logic [1:0]                    full_q, full_d, tag_q, w_full_soon;
    logic                          fill_sel_q, eng_sel_q, eng_sel_d;
    logic [2:0]                    cnt_q, n_q, n_d, j_q, j_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d, w_shift;
    logic signed [PROD_W-1:0]      w_prod;
    logic signed [COEF_WIDTH-1:0]  w_coef;
    logic signed [OUT_WIDTH-1:0]   w_sat;
    logic                          w_in_hs, w_fill_done, w_release, w_push, w_pop;
    logic signed [OUT_WIDTH-1:0]   f_data_q [2];
    logic [2:0]                    f_idx_q [2];
    logic [1:0]                    f_last_q, f_inv_q;
    logic                          f_wr_q, f_rd_q;
    logic [1:0]                    f_cnt_q;

    // Reset is folded in so no sample can be accepted while it is asserted.
    assign in_ready    = !rst_n && !full_q[fill_sel_q];
    assign w_in_hs     = in_valid && in_ready;
    assign w_fill_done = w_in_hs && (cnt_q == 3'd7);
    assign w_full_soon = full_q | (w_fill_done ? (2'b01 << fill_sel_q) : 2'b00);
    assign full_d      = w_full_soon & ~(w_release ? (2'b01 << eng_sel_q) : 2'b00);

    // Inverse mode walks the ROM transposed.
    assign w_coef  = w_rom[tag_q[eng_sel_q] ? {n_q, j_q} : {j_q, n_q}];
    assign w_prod  = PROD_W'(buf_q[eng_sel_q][n_q]) * PROD_W'(w_coef);
    assign w_shift = (acc_q + C_RND) >>> (COEF_WIDTH - 1);

    always_comb begin
        if (w_shift > C_OUT_MAX)      w_sat = C_OUT_MAX[OUT_WIDTH-1:0];
        else if (w_shift < C_OUT_MIN) w_sat = C_OUT_MIN[OUT_WIDTH-1:0];
        else                          w_sat = w_shift[OUT_WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        j_d       = j_q;
        acc_d     = acc_q;
        eng_sel_d = eng_sel_q;
        w_push    = 1'b0;
        w_release = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_full_soon[eng_sel_q]) begin
                    state_d = S_MAC;
                    n_d     = 3'd0;
                    j_d     = 3'd0;
                end
            end
            S_MAC: begin
                acc_d = ((n_q == 3'd0) ? '0 : acc_q) + ACC_W'(w_prod);
                n_d   = n_q + 3'd1;
                if (n_q == 3'd7) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (f_cnt_q != 2'd2) begin
                    w_push = 1'b1;
                    j_d    = j_q + 3'd1;
                    if (j_q == 3'd7) begin
                        w_release = 1'b1;
                        eng_sel_d = ~eng_sel_q;
                        state_d   = w_full_soon[~eng_sel_q] ? S_MAC : S_IDLE;
                    end else begin
                        state_d = S_MAC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_pop = (f_cnt_q != 2'd0) && out_ready;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            n_q        <= 3'd0;
            j_q        <= 3'd0;
            acc_q      <= '0;
            eng_sel_q  <= 1'b0;
            fill_sel_q <= 1'b0;
            cnt_q      <= 3'd0;
            full_q     <= 2'b00;
            tag_q      <= 2'b00;
            f_wr_q     <= 1'b0;
            f_rd_q     <= 1'b0;
            f_cnt_q    <= 2'd0;
            f_last_q   <= 2'b00;
            f_inv_q    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                f_data_q[i] <= '0;
                f_idx_q[i]  <= 3'd0;
            end
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            j_q       <= j_d;
            acc_q     <= acc_d;
            eng_sel_q <= eng_sel_d;
            full_q    <= full_d;
            if (w_in_hs) begin
                cnt_q <= cnt_q + 3'd1;
                if (cnt_q == 3'd0) tag_q[fill_sel_q] <= in_inv;
                if (cnt_q == 3'd7) fill_sel_q <= ~fill_sel_q;
            end
            if (w_push) begin
                f_data_q[f_wr_q] <= w_sat;
                f_idx_q[f_wr_q]  <= j_q;
                f_last_q[f_wr_q] <= (j_q == 3'd7);
                f_inv_q[f_wr_q]  <= tag_q[eng_sel_q];
                f_wr_q           <= ~f_wr_q;
            end
            if (w_pop) f_rd_q <= ~f_rd_q;
            case ({w_push, w_pop})
                2'b10:   f_cnt_q <= f_cnt_q + 2'd1;
                2'b01:   f_cnt_q <= f_cnt_q - 2'd1;
                default: f_cnt_q <= f_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_hs) buf_q[fill_sel_q][cnt_q] <= in_data;
    end

    assign out_valid = (f_cnt_q != 2'd0);
    assign out_data  = f_data_q[f_rd_q];
    assign out_index = f_idx_q[f_rd_q];
    assign out_last  = f_last_q[f_rd_q];
    assign out_inv   = f_inv_q[f_rd_q];
    assign busy      = (|full_q) || (state_q != S_IDLE) || (f_cnt_q != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_dct8_stream.sv
`default_nettype none
// =============================================================================
// Module   : tb_dct8_stream
// Brief    : Directed self-checking bench for dct8_stream.
// Revision : 1.0
// =============================================================================
module tb_dct8_stream;
    // Input wide enough to feed forward results back into the inverse.
    localparam int DW = 10;
    localparam int CW = 12;
    localparam int OW = DW + 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_inv = 1'b0;
    logic signed [OW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [2:0]           out_index;
    logic                 out_last;
    logic                 out_inv;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int q_data[$];
    int q_idx[$];
    int q_last[$];
    int q_inv[$];

    dct8_stream #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .OUT_WIDTH(OW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .out_inv   (out_inv),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n && out_valid && out_ready) begin
            q_data.push_back(int'(out_data));
            q_idx.push_back(int'(out_index));
            q_last.push_back(int'(out_last));
            q_inv.push_back(int'(out_inv));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got unfinished run, expected completion");
        $fatal(1, "timeout");
    end

    function automatic string got_str(input int i);
        if (i >= q_data.size()) return "missing";
        return $sformatf("data=%0d idx=%0d last=%0d inv=%0d", q_data[i], q_idx[i], q_last[i], q_inv[i]);
    endfunction

    task automatic clear_q();
        q_data.delete();
        q_idx.delete();
        q_last.delete();
        q_inv.delete();
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((busy || out_valid) && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (busy || out_valid) begin
            errors++;
            $display("FAIL wait_idle: busy=%0d out_valid=%0d, expected 0 0", busy, out_valid);
        end
        clear_q();
    endtask

    task automatic send_block(input int v[8], input logic inv, output int t_last, output int stalls);
        stalls = 0;
        t_last = 0;
        for (int i = 0; i < 8; i++) begin
            int guard = 0;
            in_data  = DW'(v[i]);
            in_valid = 1'b1;
            in_inv   = inv;
            @(negedge clk);
            while (!in_ready && guard < 300) begin
                @(negedge clk);
                guard++;
                stalls++;
            end
            t_last = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_inv   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, out_index, out_last, out_inv, busy, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0d data=%0d idx=%0d last=%0d inv=%0d busy=%0d rdy=%0d, expected all 0",
                     out_valid, out_data, out_index, out_last, out_inv, busy, in_ready);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%0d busy=%0d, expected 1 0", in_ready, busy);
        end
    endtask

    task automatic test_fwd_dc();
        int v[8], exp[8], t, st, guard;
        wait_idle();
        out_ready = 1'b1;
        v   = '{100, 100, 100, 100, 100, 100, 100, 100};
        exp = '{283, 0, 0, 0, 0, 0, 0, 0};
        send_block(v, 1'b0, t, st);
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (cyc != t + 10) begin
            errors++;
            $display("FAIL fwd_dc_latency: got first out_valid at cycle %0d, expected %0d", cyc, t + 10);
        end
        guard = 0;
        while (q_data.size() < 8 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= q_data.size() || q_data[i] != exp[i] || q_idx[i] != i || q_last[i] != int'(i == 7) || q_inv[i] != 0) begin
                errors++;
                $display("FAIL fwd_dc[%0d]: got %s, expected data=%0d idx=%0d last=%0d inv=0",
                         i, got_str(i), exp[i], i, int'(i == 7));
            end
        end
    endtask

    task automatic test_fwd_extreme();
        int v[8], exp[8], t, st, guard;
        wait_idle();
        out_ready = 1'b1;
        v   = '{-128, -128, -128, -128, -128, -128, -128, -128};
        exp = '{-362, 0, 0, 0, 0, 0, 0, 0};
        send_block(v, 1'b0, t, st);
        guard = 0;
        while (q_data.size() < 8 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= q_data.size() || q_data[i] != exp[i] || q_idx[i] != i || q_inv[i] != 0) begin
                errors++;
                $display("FAIL fwd_extreme[%0d]: got %s, expected data=%0d idx=%0d inv=0", i, got_str(i), exp[i], i);
            end
        end
    endtask

    task automatic test_inverse();
        int v[8], t, st, guard;
        wait_idle();
        out_ready = 1'b1;
        v = '{283, 0, 0, 0, 0, 0, 0, 0};
        send_block(v, 1'b1, t, st);
        guard = 0;
        while (q_data.size() < 8 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= q_data.size() || q_data[i] != 100 || q_idx[i] != i || q_last[i] != int'(i == 7) || q_inv[i] != 1) begin
                errors++;
                $display("FAIL inverse[%0d]: got %s, expected data=100 idx=%0d last=%0d inv=1",
                         i, got_str(i), i, int'(i == 7));
            end
        end
    endtask

    task automatic test_back_to_back();
        int va[8], vb[8], exp[16], ta, tb, sa, sb, guard;
        wait_idle();
        out_ready = 1'b1;
        va  = '{50, 50, 50, 50, 50, 50, 50, 50};
        vb  = '{0, 256, 0, 0, 0, 0, 0, 0};
        exp = '{141, 0, 0, 0, 0, 0, 0, 0, 126, 106, 71, 25, -25, -71, -106, -125};
        send_block(va, 1'b0, ta, sa);
        send_block(vb, 1'b1, tb, sb);
        checks++;
        if (sa != 0 || sb != 0 || tb != ta + 8) begin
            errors++;
            $display("FAIL b2b_accept: got stalls=%0d/%0d span=%0d, expected 0/0 span 8", sa, sb, tb - ta);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_drop: got in_ready=%0d, expected 0", in_ready);
        end
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (cyc != ta + 73) begin
            errors++;
            $display("FAIL b2b_release: got in_ready rise at cycle %0d, expected %0d", cyc, ta + 73);
        end
        guard = 0;
        while (q_data.size() < 16 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= q_data.size() || q_data[i] != exp[i] || q_idx[i] != i % 8 ||
                q_last[i] != int'(i % 8 == 7) || q_inv[i] != int'(i >= 8)) begin
                errors++;
                $display("FAIL b2b[%0d]: got %s, expected data=%0d idx=%0d last=%0d inv=%0d",
                         i, got_str(i), exp[i], i % 8, int'(i % 8 == 7), int'(i >= 8));
            end
        end
    endtask

    task automatic test_backpressure();
        int v[8], exp[8], t, st, guard, held;
        logic prev_hold;
        logic signed [OW-1:0] prev_d;
        logic [2:0] prev_i;
        wait_idle();
        out_ready = 1'b1;
        v   = '{256, 0, 0, 0, 0, 0, 0, 0};
        exp = '{91, 126, 118, 106, 91, 71, 49, 25};
        send_block(v, 1'b0, t, st);
        guard = 0;
        while (q_data.size() < 1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        prev_hold = 1'b0;
        prev_d    = '0;
        prev_i    = '0;
        held      = 0;
        guard     = 0;
        while (q_data.size() < 8 && guard < 1000) begin
            @(negedge clk);
            if (prev_hold) begin
                checks++;
                if (out_data !== prev_d || out_index !== prev_i) begin
                    errors++;
                    $display("FAIL bp_stable: got data=%0d idx=%0d, expected data=%0d idx=%0d", out_data, out_index, prev_d, prev_i);
                end
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_busy: got busy=%0d with %0d results drained, expected 1", busy, q_data.size());
            end
            prev_hold = out_valid && !out_ready;
            prev_d    = out_data;
            prev_i    = out_index;
            @(posedge clk); #1;
            held++;
            guard++;
            out_ready = (held < 40) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got busy=%0d out_valid=%0d, expected 0 0", busy, out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= q_data.size() || q_data[i] != exp[i] || q_idx[i] != i || q_last[i] != int'(i == 7)) begin
                errors++;
                $display("FAIL bp[%0d]: got %s, expected data=%0d idx=%0d last=%0d", i, got_str(i), exp[i], i, int'(i == 7));
            end
        end
        checks++;
        if (q_data.size() != 8) begin
            errors++;
            $display("FAIL bp_count: got %0d results, expected 8", q_data.size());
        end
    endtask

    task automatic test_reset_mid();
        int v[8], t, st, guard;
        wait_idle();
        out_ready = 1'b1;
        v = '{100, 100, 100, 100, 100, 100, 100, 100};
        send_block(v, 1'b1, t, st);
        for (int i = 0; i < 3; i++) begin
            in_data  = DW'(7);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_data, out_index, out_last, out_inv, busy, in_ready} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got valid=%0d data=%0d idx=%0d last=%0d inv=%0d busy=%0d rdy=%0d, expected all 0",
                     out_valid, out_data, out_index, out_last, out_inv, busy, in_ready);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_ready: got in_ready=%0d, expected 1", in_ready);
        end
        clear_q();
        send_block(v, 1'b0, t, st);
        guard = 0;
        while (q_data.size() < 8 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (q_data.size() != 8) begin
            errors++;
            $display("FAIL rst_mid_count: got %0d results, expected 8", q_data.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= q_data.size() || q_data[i] != ((i == 0) ? 283 : 0) || q_idx[i] != i || q_inv[i] != 0) begin
                errors++;
                $display("FAIL rst_mid[%0d]: got %s, expected data=%0d idx=%0d inv=0",
                         i, got_str(i), (i == 0) ? 283 : 0, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_dc();
        test_fwd_extreme();
        test_inverse();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dct8_stream.md
# dct8_stream

Streaming 1-D 8-point orthonormal DCT-II / DCT-III (inverse) engine with valid/ready handshakes on both sides, signed fixed-point arithmetic and a per-block mode select. It is the parametrised successor to the fixed-coefficient systolic DCT: it has real coefficients, width growth with rounding and saturation, backpressure and a ping-pong input buffer. It sits between the pixel/residual stream and the transpose buffer, and is instantiated twice for a separable 2-D transform.

## Interface
- DATA_WIDTH, 8, signed input sample width
- COEF_WIDTH, 12, signed coefficient width; coefficients are Q0.(COEF_WIDTH-1)
- OUT_WIDTH, DATA_WIDTH+3, signed output width
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset; synchronous, active-high (name kept consistent with the other DCT blocks)
- in_data  in  DATA_WIDTH  signed sample (forward) or coefficient (inverse)
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_inv  in  1  mode: 0 = forward DCT-II, 1 = inverse; sampled only with sample 0 of a block
- out_data  out  OUT_WIDTH  signed result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_index  out  3  result index k (forward) or n (inverse), 0..7
- out_last  out  1  high with index 7
- out_inv  out  1  mode tag of the block being output
- busy  out  1  any buffer full, engine active or output FIFO non-empty

## Operation
- Input: a sample is transferred when in_valid && in_ready. Each transfer writes the current fill buffer at address cnt (0..7). When cnt wraps from 7 to 0, the buffer is marked full and the mode tag is latched with it.
- Ping-pong: two 8-entry buffers. in_ready=1 iff the fill buffer is not full. in_ready depends only on state, never on in_valid.
- Coefficient ROM: C[k][n] = round(a(k)·cos((2n+1)kπ/16)·2^(COEF_WIDTH-1)), with a(0)=1/√8 and a(k>0)=1/2. Round half away from zero; values are elaborated from parameters. At COEF_WIDTH=12: C[0][n]=724.
- Engine FSM:
  - IDLE: go to MAC when a full buffer exists. Oldest buffer first.
  - MAC: 8 inner cycles per output index j. Forward accumulates buf[n]·C[j][n]; inverse accumulates buf[n]·C[n][j]. Go to WRITE.
  - WRITE: push the rounded result to the output FIFO. If the FIFO is full, stay in WRITE (stall). After j=7, release the buffer and go to IDLE, or straight to MAC if the other buffer is full.
- Arithmetic: product width DATA_WIDTH+COEF_WIDTH; accumulator width DATA_WIDTH+COEF_WIDTH+3, no overflow possible. Result = (acc + 2^(COEF_WIDTH-2)) >>> (COEF_WIDTH-1), i.e. round half up with arithmetic shift, then saturate to OUT_WIDTH.
- Output: 2-entry FIFO holding {data, index, last, inv}. out_valid = FIFO non-empty. Head fields stay stable until out_ready.
- Simultaneous events:
  - Buffer release and new fill completion in the same cycle are both honoured.
  - A FIFO push and pop in the same cycle keeps the occupancy unchanged.
- Reset: all outputs 0, except in_ready=0 during reset and 1 in the first cycle after reset. Buffers empty, counters 0, FSM IDLE, FIFO empty. Reset mid-block discards all partial data.

## Timing
- Sample 7 handshake at cycle T. The engine starts at T+1, MAC runs T+1..T+8, WRITE at T+9, and out_valid rises at T+10 if the FIFO was empty.
- Without backpressure, results follow every 9 cycles (MAC 8 + WRITE 1). One block takes 72 cycles.
- Input accepts 16 samples back-to-back after idle. in_ready then falls until the first buffer is released at T+72.
- Backpressure: with out_ready=0 the FIFO fills after 2 results. The engine then stalls in WRITE and no result is lost or duplicated.

## Test plan
- Forward DC: inv=0, eight samples of 100 → out_data 283, 0, 0, 0, 0, 0, 0, 0 with index 0..7, last on index 7, first out_valid at T+10.
- Forward extreme: eight samples of −128 → index 0 gives −362, all others 0. No saturation flag and no overflow.
- Inverse round-trip: inv=1, samples 283, 0×7 → eight outputs of 100. out_inv=1 on every output.
- Mode interleave plus ping-pong: a forward block and an inverse block sent back-to-back (16 samples, no gaps) → in_ready stays 1 for 16 cycles then drops. Results come out in order with correct per-block out_inv.
- Backpressure: out_ready held 0 for 40 cycles mid-block, then random toggling → all 8 results match the golden model, out_data stays stable while out_valid && !out_ready, busy stays 1 until drained.
- Reset mid-operation: rst_n pulsed during MAC of block 1 while block 2 is filling → next cycle all outputs are 0, the following cycle in_ready=1, and a fresh DC block then yields 283 with index 0.
